// File: rtl/cpu_sw_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_sw_ctrl
//  Description : Avalon-MM slave for the slide-switch port. Synchronises and
//                debounces the raw pins, latches changes of the debounced
//                value, and raises a maskable level interrupt.
//  Revision    : 1.0 - initial release
// ============================================================================
module cpu_sw_ctrl #(
    parameter int WIDTH      = 3,
    parameter int DB_W       = 20,
    parameter int DB_DEFAULT = 50000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    localparam logic [1:0]      ADDR_DATA   = 2'd0;
    localparam logic [1:0]      ADDR_MASK   = 2'd1;
    localparam logic [1:0]      ADDR_EDGE   = 2'd2;
    localparam logic [1:0]      ADDR_PERIOD = 2'd3;
    localparam logic [DB_W-1:0] DB_ONE      = DB_W'(1);
    localparam logic [DB_W-1:0] DB_RESET    = DB_W'(DB_DEFAULT);

    logic             wr_en;
    logic             wr_mask;
    logic             wr_edge;
    logic             wr_period;
    logic [WIDTH-1:0] sync_meta;
    logic [WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] stable_d;
    logic [WIDTH-1:0] chg;
    logic [WIDTH-1:0] w1c;
    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] edge_cap;
    logic [DB_W-1:0]  period;
    logic [DB_W-1:0]  eff_period;
    logic [DB_W-1:0]  cnt [WIDTH];
    logic [31:0]      rd_next;
    logic             unused_wdata;

    assign wr_en     = chipselect & ~write_n;
    assign wr_mask   = wr_en && (address == ADDR_MASK);
    assign wr_edge   = wr_en && (address == ADDR_EDGE);
    assign wr_period = wr_en && (address == ADDR_PERIOD);

    // A period of zero behaves as one so a change is still accepted next cycle.
    assign eff_period = (period == '0) ? DB_ONE : period;

    // Edge detect on the debounced value, one cycle behind the stable update.
    assign chg = stable ^ stable_d;
    assign w1c = wr_edge ? writedata[WIDTH-1:0] : '0;

    assign unused_wdata = ^writedata[31:DB_W];

    // Two-flop synchroniser for the asynchronous switch pins.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_meta <= '0;
            sync_q    <= '0;
        end else begin
            sync_meta <= in_port;
            sync_q    <= sync_meta;
        end
    end

    // Per-bit debounce: accept a new level after eff_period consecutive cycles.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stable   <= '0;
            stable_d <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            stable_d <= stable;
            for (int i = 0; i < WIDTH; i++) begin
                if (wr_period) begin
                    // New period restarts any debounce in progress.
                    cnt[i] <= '0;
                end else if (sync_q[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] >= eff_period - DB_ONE) begin
                    stable[i] <= sync_q[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + DB_ONE;
                end
            end
        end
    end

    // Software-visible registers; a fresh edge wins over a same-cycle W1C.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mask     <= '0;
            edge_cap <= '0;
            period   <= DB_RESET;
        end else begin
            edge_cap <= chg | (edge_cap & ~w1c);
            if (wr_mask) begin
                mask <= writedata[WIDTH-1:0];
            end
            if (wr_period) begin
                period <= writedata[DB_W-1:0];
            end
        end
    end

    // Read mux, unused upper bits return zero.
    always_comb begin
        rd_next = '0;
        case (address)
            ADDR_DATA:   rd_next[WIDTH-1:0] = stable;
            ADDR_MASK:   rd_next[WIDTH-1:0] = mask;
            ADDR_EDGE:   rd_next[WIDTH-1:0] = edge_cap;
            ADDR_PERIOD: rd_next[DB_W-1:0]  = period;
            default:     rd_next = '0;
        endcase
    end

    // Registered read data and interrupt, each one cycle behind its source.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            readdata <= '0;
            irq      <= 1'b0;
        end else begin
            readdata <= rd_next;
            irq      <= |(edge_cap & mask);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cpu_sw_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cpu_sw_ctrl
//  Description : Self-checking bench for cpu_sw_ctrl (vector table, directed
//                corner sequences, randomized traffic against a reference model)
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_sw_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'd0;
    logic [31:0] readdata;
    logic [2:0]  in_port = 3'd0;
    logic        irq;

    int n_checks = 0;
    int n_errors = 0;

    cpu_sw_ctrl #(
        .WIDTH(3),
        .DB_W(20),
        .DB_DEFAULT(50000)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .address(address),
        .chipselect(chipselect),
        .write_n(write_n),
        .writedata(writedata),
        .readdata(readdata),
        .in_port(in_port),
        .irq(irq)
    );

    always #5 clk = ~clk;

    // Reference model state: pin pipeline, accepted level, run lengths.
    logic [2:0]  m_pipe1, m_pipe2, m_level, m_level_prev, m_mask, m_edges;
    logic [19:0] m_period;
    int          m_run [3];
    logic        m_irq;
    logic [31:0] m_rd;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model by one clock using the inputs as presented this cycle.
    task automatic model_step();
        logic [2:0]  new_level;
        logic [31:0] new_rd;
        int          hold_needed;
        bit          wr;
        if (!reset_n) begin
            m_pipe1 = 0; m_pipe2 = 0; m_level = 0; m_level_prev = 0;
            m_mask = 0; m_edges = 0; m_period = 20'd50000; m_irq = 0; m_rd = 0;
            for (int i = 0; i < 3; i++) m_run[i] = 0;
            return;
        end
        wr = chipselect && !write_n;
        hold_needed = (m_period == 20'd0) ? 1 : int'(m_period);
        case (address)
            2'd0:    new_rd = {29'd0, m_level};
            2'd1:    new_rd = {29'd0, m_mask};
            2'd2:    new_rd = {29'd0, m_edges};
            default: new_rd = {12'd0, m_period};
        endcase
        new_level = m_level;
        for (int i = 0; i < 3; i++) begin
            if (wr && address == 2'd3) m_run[i] = 0;
            else if (m_pipe2[i] == m_level[i]) m_run[i] = 0;
            else begin
                m_run[i] = m_run[i] + 1;
                if (m_run[i] >= hold_needed) begin
                    new_level[i] = m_pipe2[i];
                    m_run[i] = 0;
                end
            end
        end
        m_irq = |(m_edges & m_mask);
        for (int i = 0; i < 3; i++) begin
            if (m_level[i] != m_level_prev[i]) m_edges[i] = 1'b1;
            else if (wr && address == 2'd2 && writedata[i]) m_edges[i] = 1'b0;
        end
        if (wr && address == 2'd1) m_mask = writedata[2:0];
        if (wr && address == 2'd3) m_period = writedata[19:0];
        m_level_prev = m_level;
        m_level = new_level;
        m_pipe2 = m_pipe1;
        m_pipe1 = in_port;
        m_rd = new_rd;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check("model_readdata", readdata, m_rd);
        check("model_irq", {31'd0, irq}, {31'd0, m_irq});
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
        tick();
        chipselect = 1'b0; write_n = 1'b1; writedata = 32'd0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        ticks(2);
        reset_n = 1'b1;
    endtask

    typedef struct {
        logic        do_wr;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs [11];

    logic [2:0] flip;

    initial begin
        vecs[0]  = '{1'b0, 2'd0, 32'd0,          32'd0};
        vecs[1]  = '{1'b0, 2'd1, 32'd0,          32'd0};
        vecs[2]  = '{1'b0, 2'd2, 32'd0,          32'd0};
        vecs[3]  = '{1'b0, 2'd3, 32'd0,          32'd50000};
        vecs[4]  = '{1'b1, 2'd1, 32'hFFFF_FFFF,  32'd7};
        vecs[5]  = '{1'b1, 2'd1, 32'd5,          32'd5};
        vecs[6]  = '{1'b1, 2'd0, 32'hFFFF_FFFF,  32'd0};
        vecs[7]  = '{1'b1, 2'd2, 32'hFFFF_FFFF,  32'd0};
        vecs[8]  = '{1'b1, 2'd3, 32'hFFFF_FFFF,  32'h000F_FFFF};
        vecs[9]  = '{1'b1, 2'd3, 32'd4,          32'd4};
        vecs[10] = '{1'b1, 2'd1, 32'd0,          32'd0};

        // Reset state and register map.
        do_reset();
        check("reset_irq", {31'd0, irq}, 32'd0);
        for (int v = 0; v < 11; v++) begin
            if (vecs[v].do_wr) bus_write(vecs[v].addr, vecs[v].wdata);
            address = vecs[v].addr;
            tick();
            check($sformatf("vec%0d_readdata", v), readdata, vecs[v].exp_rd);
        end

        // PERIOD=4: stable after 2+4 edges, EDGE one cycle later, no irq.
        bus_write(2'd3, 32'd4);
        address = 2'd0;
        in_port = 3'b001;
        ticks(6);
        check("p4_data_before", readdata, 32'd0);
        tick();
        check("p4_data_after", readdata, 32'd1);
        address = 2'd2;
        tick();
        check("p4_edge", readdata, 32'd1);
        check("p4_irq_masked", {31'd0, irq}, 32'd0);

        // Glitches shorter than the period are rejected.
        in_port = 3'b000;
        do_reset();
        bus_write(2'd3, 32'd8);
        address = 2'd0;
        for (int g = 0; g < 4; g++) begin
            in_port = 3'b010; tick();
            in_port = 3'b000; ticks(4);
        end
        check("glitch_data", readdata, 32'd0);
        address = 2'd2;
        tick();
        check("glitch_edge", readdata, 32'd0);
        address = 2'd0;
        in_port = 3'b010;
        ticks(10);
        check("hold8_data_before", readdata, 32'd0);
        tick();
        check("hold8_data_after", readdata, 32'd2);

        // Masked interrupt and W1C clear.
        bus_write(2'd2, 32'd7);
        bus_write(2'd1, 32'd4);
        address = 2'd2;
        in_port = 3'b110;
        ticks(11);
        check("irq_before", {31'd0, irq}, 32'd0);
        tick();
        check("irq_set", {31'd0, irq}, 32'd1);
        check("irq_edge_val", readdata, 32'd4);
        bus_write(2'd2, 32'd4);
        check("irq_hold_on_w1c", {31'd0, irq}, 32'd1);
        address = 2'd2;
        tick();
        check("irq_cleared", {31'd0, irq}, 32'd0);
        check("edge_cleared", readdata, 32'd0);

        // Set and W1C on the same edge: set wins.
        in_port = 3'b000;
        do_reset();
        bus_write(2'd3, 32'd4);
        address = 2'd0;
        in_port = 3'b001;
        ticks(6);
        bus_write(2'd2, 32'd1);
        address = 2'd2;
        tick();
        check("set_wins_w1c", readdata, 32'd1);
        bus_write(2'd2, 32'd1);
        address = 2'd2;
        tick();
        check("w1c_after_set", readdata, 32'd0);

        // PERIOD=0 acts as 1; period write restarts the count.
        in_port = 3'b000;
        do_reset();
        bus_write(2'd3, 32'd0);
        address = 2'd0;
        in_port = 3'b001;
        ticks(3);
        check("p0_data_before", readdata, 32'd0);
        tick();
        check("p0_data_after", readdata, 32'd1);
        bus_write(2'd3, 32'd6);
        address = 2'd0;
        in_port = 3'b011;
        ticks(5);
        bus_write(2'd3, 32'd6);
        address = 2'd0;
        ticks(6);
        check("restart_data_before", readdata, 32'd1);
        tick();
        check("restart_data_after", readdata, 32'd3);

        // Reset in the middle of a count, then re-capture of held switches.
        bus_write(2'd1, 32'd7);
        in_port = 3'b111;
        ticks(4);
        check("pre_reset_irq", {31'd0, irq}, 32'd1);
        address = 2'd3;
        reset_n = 1'b0;
        tick();
        check("midreset_readdata", readdata, 32'd0);
        check("midreset_irq", {31'd0, irq}, 32'd0);
        reset_n = 1'b1;
        bus_write(2'd3, 32'd2);
        address = 2'd2;
        ticks(8);
        check("recapture_edge", readdata, 32'd7);

        // Randomized traffic checked every cycle against the model.
        for (int n = 0; n < 3000; n++) begin
            flip = 3'd0;
            for (int b = 0; b < 3; b++) if ($urandom_range(0, 7) == 0) flip[b] = 1'b1;
            in_port    = in_port ^ flip;
            address    = 2'($urandom_range(0, 3));
            chipselect = ($urandom_range(0, 3) == 0);
            write_n    = ($urandom_range(0, 1) == 1);
            writedata  = (address == 2'd3) ? 32'($urandom_range(0, 5)) : 32'($urandom);
            reset_n    = ($urandom_range(0, 499) != 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
